// File: rtl/decode_buffer_pkg.sv
// Shared decoder header: instruction/PC widths, decoded-pack layout and the
// classification helper used by both the decoder and the buffer's lane gating.
package decode_buffer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned INST = 32;

    typedef logic [INST-1:0] inst_t;

    // ebreak encoding doubles as the halt instruction
    localparam inst_t HaltInst = 32'h0010_0073;

    typedef enum logic [2:0] {
        OpLui,
        OpAdd,
        OpAddi,
        OpHalt,
        OpIllegal
    } op_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        op_e             op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            halt;
        logic            illegal;
    } dec_pack_t;

    function automatic op_e classify(inst_t inst);
        op_e op;
        op = OpIllegal;
        if (inst == HaltInst) begin
            op = OpHalt;
        end else begin
            case (inst[6:0])
                7'h37: op = OpLui;
                7'h33: if (inst[14:12] == 3'b000 && inst[31:25] == 7'b0) op = OpAdd;
                7'h13: if (inst[14:12] == 3'b000) op = OpAddi;
                default: op = OpIllegal;
            endcase
        end
        return op;
    endfunction

    // Halt and illegal both stop younger lanes from issuing
    function automatic logic is_stop(inst_t inst);
        op_e op;
        op = classify(inst);
        return (op == OpHalt) || (op == OpIllegal);
    endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// Fetch-side and dispatch-side signals of the decode buffer.
interface decode_buffer_if
    import decode_buffer_pkg::*;
#(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned DISP_W  = 2,
    parameter int unsigned DEPTH   = 8
) ();

    logic                               flush;
    logic [FETCH_W-1:0]                 in_valid;
    inst_t [FETCH_W-1:0]                in_inst;
    logic [FETCH_W-1:0][XLEN-1:0]       in_pc;
    logic                               in_ready;
    logic [DISP_W-1:0]                  out_valid;
    dec_pack_t [DISP_W-1:0]             out_pack;
    logic [$clog2(DISP_W+1)-1:0]        out_accept;
    logic [$clog2(DEPTH+1)-1:0]         count;
    logic                               halted;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_accept,
        input  in_ready, out_valid, out_pack, count, halted
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_accept,
        output in_ready, out_valid, out_pack, count, halted
    );

endinterface

// File: rtl/decode_buffer_dec.sv
// Single-lane combinational decoder. An invalid or flushed lane still decodes
// its fields but never reports itself valid.
module decode_buffer_dec
    import decode_buffer_pkg::*;
(
    input  logic            valid_i,
    input  logic            flush_i,
    input  inst_t           inst_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_pack_t       pack_o
);

    op_e op;

    // Field extraction and immediate formation
    always_comb begin
        op             = classify(inst_i);
        pack_o         = '0;
        pack_o.valid   = valid_i && !flush_i;
        pack_o.pc      = pc_i;
        pack_o.op      = op;
        pack_o.rd      = inst_i[11:7];
        pack_o.rs1     = inst_i[19:15];
        pack_o.rs2     = inst_i[24:20];
        case (op)
            OpLui:   pack_o.imm = {inst_i[31:12], 12'b0};
            OpAddi:  pack_o.imm = {{20{inst_i[31]}}, inst_i[31:20]};
            default: pack_o.imm = '0;
        endcase
        pack_o.halt    = valid_i && (op == OpHalt);
        pack_o.illegal = valid_i && (op == OpIllegal);
    end

endmodule

// File: rtl/decode_buffer.sv
// Circular fetch-to-decode buffer: up to FETCH_W entries in, up to DISP_W
// decoded entries out per cycle; a consumed halt/illegal freezes the pipe.
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned DISP_W  = 2,
    parameter int unsigned DEPTH   = 8
) (
    input logic            clk,
    input logic            rst_n,
    decode_buffer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < FETCH_W + DISP_W) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least FETCH_W + DISP_W");
    end

    inst_t           inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    ptr_t            head_q, head_d, tail_q, tail_d;
    cnt_t            count_q, count_d;
    logic            halted_q, halted_d;

    logic              in_ready;
    logic              do_enq;
    cnt_t              enq_n;
    logic              blocked;
    ptr_t              lane_idx   [DISP_W];
    logic [DISP_W-1:0] lane_stop;
    logic [DISP_W-1:0] lane_valid;
    dec_pack_t         lane_pack  [DISP_W];

    // Readiness looks only at registered occupancy, never at this cycle's dequeue
    assign in_ready = !halted_q && ((DEPTH - 32'(count_q)) >= FETCH_W);
    assign do_enq   = in_ready && !bus.flush;

    // Lane count of the fetch group (lanes are contiguous from 0)
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            enq_n = enq_n + cnt_t'(bus.in_valid[i]);
        end
    end

    // Lane k shows entry head+k; a halt/illegal lane closes off younger lanes
    always_comb begin
        blocked = halted_q;
        for (int k = 0; k < DISP_W; k++) begin
            lane_idx[k]   = head_q + ptr_t'(k);
            lane_stop[k]  = is_stop(inst_q[lane_idx[k]]);
            lane_valid[k] = !blocked && (k < int'(count_q));
            if (lane_valid[k] && lane_stop[k]) blocked = 1'b1;
        end
    end

    for (genvar k = 0; k < DISP_W; k++) begin : g_dec
        decode_buffer_dec u_dec (
            .valid_i (lane_valid[k]),
            .flush_i (bus.flush),
            .inst_i  (inst_q[lane_idx[k]]),
            .pc_i    (pc_q[lane_idx[k]]),
            .pack_o  (lane_pack[k])
        );
    end

    // Drive dispatch-side outputs
    always_comb begin
        for (int k = 0; k < DISP_W; k++) begin
            bus.out_pack[k] = lane_pack[k];
        end
        bus.out_valid = lane_valid;
        bus.in_ready  = in_ready;
        bus.count     = count_q;
        bus.halted    = halted_q;
    end

    // Pointer/occupancy update; flush wins over both enqueue and dequeue
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (bus.flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            head_d  = head_q + ptr_t'(bus.out_accept);
            tail_d  = do_enq ? tail_q + ptr_t'(enq_n) : tail_q;
            count_d = count_q + (do_enq ? enq_n : cnt_t'(0)) - cnt_t'(bus.out_accept);
            for (int k = 0; k < DISP_W; k++) begin
                if (k < int'(bus.out_accept) && lane_valid[k] && lane_stop[k]) halted_d = 1'b1;
            end
        end
    end

    // Entry storage; contents are meaningless outside head..tail so no reset
    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < int'(enq_n)) begin
                    inst_q[tail_q + ptr_t'(i)] <= bus.in_inst[i];
                    pc_q[tail_q + ptr_t'(i)]   <= bus.in_pc[i];
                end
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_decode_buffer.sv
// Bench for decode_buffer: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    localparam int unsigned FETCH_W = 2;
    localparam int unsigned DISP_W  = 2;
    localparam int unsigned DEPTH   = 8;

    localparam inst_t I_LUI  = 32'h1234_5037;
    localparam inst_t I_ADD  = 32'h0031_00b3;
    localparam inst_t I_ADDI = 32'h0050_0093;
    localparam inst_t I_HALT = 32'h0010_0073;
    localparam inst_t I_ILL  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_buffer_if #(.FETCH_W(FETCH_W), .DISP_W(DISP_W), .DEPTH(DEPTH)) bus ();

    decode_buffer #(.FETCH_W(FETCH_W), .DISP_W(DISP_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        inst_t       inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        int         n;
        int         acc;
        bit         fl;
        int         exp_cnt;
        bit         exp_rdy;
        logic [1:0] exp_ov;
    } vec_t;

    ent_t        mq[$];
    bit          m_halted;
    logic [31:0] pc_ctr;
    int          n_checks;
    int          n_errs;
    vec_t        tbl[9];
    inst_t       pool[3];

    function automatic bit ref_stop(inst_t i);
        bit legal;
        legal = (i[6:0] == 7'h37) ||
                (i[6:0] == 7'h33 && i[14:12] == 3'b000 && i[31:25] == 7'b0) ||
                (i[6:0] == 7'h13 && i[14:12] == 3'b000);
        return (i == I_HALT) || !legal;
    endfunction

    function automatic bit model_ready();
        return !m_halted && (int'(DEPTH) - mq.size() >= int'(FETCH_W));
    endfunction

    function automatic int model_nvalid();
        int n;
        n = 0;
        if (m_halted) return 0;
        for (int k = 0; k < DISP_W; k++) begin
            if (k >= mq.size()) break;
            n++;
            if (ref_stop(mq[k].inst)) break;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int nv;
        nv = model_nvalid();
        chk("count", 64'(bus.count), 64'(mq.size()));
        chk("in_ready", 64'(bus.in_ready), 64'(model_ready()));
        chk("halted", 64'(bus.halted), 64'(m_halted));
        chk("out_valid", 64'(bus.out_valid), 64'((1 << nv) - 1));
        for (int k = 0; k < nv; k++) begin
            chk("lane_pc", 64'(bus.out_pack[k].pc), 64'(mq[k].pc));
            chk("lane_stop", 64'(bus.out_pack[k].halt | bus.out_pack[k].illegal),
                64'(ref_stop(mq[k].inst)));
        end
    endtask

    // One clock: drive, check pre-edge state at negedge, advance the model at posedge
    task automatic step(input int n, input inst_t i0, input inst_t i1, input int acc, input bit fl);
        bit rdy;
        bus.in_valid   = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
        bus.in_inst[0] = i0;
        bus.in_inst[1] = i1;
        bus.in_pc[0]   = pc_ctr;
        bus.in_pc[1]   = pc_ctr + 32'd4;
        bus.out_accept = 2'(acc);
        bus.flush      = fl;
        @(negedge clk);
        check_outputs();
        rdy = model_ready();
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            for (int k = 0; k < acc; k++) begin
                if (mq.size() > 0) begin
                    if (ref_stop(mq[0].inst)) m_halted = 1'b1;
                    void'(mq.pop_front());
                end
            end
            if (rdy) begin
                if (n > 0) mq.push_back('{i0, pc_ctr});
                if (n > 1) mq.push_back('{i1, pc_ctr + 32'd4});
                pc_ctr = pc_ctr + 32'(4 * n);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = '0;
        bus.in_inst    = '0;
        bus.in_pc      = '0;
        bus.out_accept = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_halted = 1'b0;
        pc_ctr = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int acc;
        bit fl;
        n_checks = 0;
        n_errs   = 0;
        pc_ctr   = '0;
        m_halted = 1'b0;
        pool[0] = I_LUI;
        pool[1] = I_ADD;
        pool[2] = I_ADDI;

        // n, acc, flush, count after, in_ready after, out_valid after
        tbl[0] = '{2, 0, 1'b0, 2, 1'b1, 2'b11};
        tbl[1] = '{2, 0, 1'b0, 4, 1'b1, 2'b11};
        tbl[2] = '{2, 0, 1'b0, 6, 1'b1, 2'b11};
        tbl[3] = '{1, 0, 1'b0, 7, 1'b0, 2'b11};
        tbl[4] = '{2, 0, 1'b0, 7, 1'b0, 2'b11};
        tbl[5] = '{0, 2, 1'b0, 5, 1'b1, 2'b11};
        tbl[6] = '{2, 2, 1'b0, 5, 1'b1, 2'b11};
        tbl[7] = '{2, 1, 1'b1, 0, 1'b1, 2'b00};
        tbl[8] = '{2, 0, 1'b0, 2, 1'b1, 2'b11};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].n, I_LUI, I_LUI, tbl[i].acc, tbl[i].fl);
            chk("tbl_count", 64'(bus.count), 64'(tbl[i].exp_cnt));
            chk("tbl_in_ready", 64'(bus.in_ready), 64'(tbl[i].exp_rdy));
            chk("tbl_out_valid", 64'(bus.out_valid), 64'(tbl[i].exp_ov));
            if (i == 0) chk("tbl_lane0_pc", 64'(bus.out_pack[0].pc), 64'd0);
        end

        // Steady two-in/two-out across pointer wrap
        do_reset();
        step(2, I_ADD, I_ADDI, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(2, I_LUI, I_ADD, 2, 1'b0);
            chk("steady_count", 64'(bus.count), 64'd2);
        end

        // Halt in lane 1, then consume it
        do_reset();
        step(2, I_ADD, I_HALT, 0, 1'b0);
        step(1, I_ADD, I_ADD, 0, 1'b0);
        chk("halt_out_valid", 64'(bus.out_valid), 64'b11);
        chk("halt_lane1", 64'(bus.out_pack[1].halt), 64'd1);
        step(0, I_ADD, I_ADD, 2, 1'b0);
        chk("halted_set", 64'(bus.halted), 64'd1);
        chk("halted_out_valid", 64'(bus.out_valid), 64'd0);
        chk("halted_in_ready", 64'(bus.in_ready), 64'd0);
        step(2, I_ADD, I_ADD, 0, 1'b0);
        step(2, I_ADD, I_ADD, 0, 1'b0);
        chk("halted_count", 64'(bus.count), 64'd1);

        // Illegal in lane 0 closes lane 1
        do_reset();
        step(2, I_ILL, I_ADD, 0, 1'b0);
        chk("ill_out_valid", 64'(bus.out_valid), 64'b01);
        step(0, I_ADD, I_ADD, 1, 1'b0);
        chk("ill_halted", 64'(bus.halted), 64'd1);

        // Randomized traffic with occasional flush
        do_reset();
        for (int i = 0; i < 400; i++) begin
            n   = int'($urandom_range(0, 2));
            acc = int'($urandom_range(0, model_nvalid()));
            fl  = ($urandom_range(0, 19) == 0);
            step(n, pool[$urandom_range(0, 2)], pool[$urandom_range(0, 2)], acc, fl);
        end

        // Asynchronous reset mid-cycle with four entries held
        do_reset();
        step(2, I_ADD, I_LUI, 0, 1'b0);
        step(2, I_ADDI, I_ADD, 0, 1'b0);
        idle_inputs();
        chk("pre_async_count", 64'(bus.count), 64'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", 64'(bus.count), 64'd0);
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_halted", 64'(bus.halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_halted = 1'b0;
        pc_ctr = '0;
        @(posedge clk);
        #1;
        step(2, I_LUI, I_ADD, 0, 1'b0);
        step(0, I_LUI, I_ADD, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameter FETCH_W, default 2: instructions the buffer can accept per cycle.
REQ-002 Parameter DISP_W, default 2: decoded instructions the buffer can present per cycle.
REQ-003 Parameter DEPTH, default 8: number of entries; SHALL be a power of two and SHALL be at least FETCH_W+DISP_W.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  discards all buffered entries (mispredict/exception recovery).
REQ-007 in_valid  in  FETCH_W  per-lane fetch valid; set lanes are contiguous from lane 0.
REQ-008 in_inst  in  FETCH_W x INST  raw instruction per lane.
REQ-009 in_pc  in  FETCH_W x XLEN  PC per lane.
REQ-010 in_ready  out  1  high when free entries >= FETCH_W.
REQ-011 out_valid  out  DISP_W  per-lane valid decoded output; set lanes are contiguous from lane 0.
REQ-012 out_pack  out  DISP_W x DECODED_PACK  decoded instruction per lane, oldest on lane 0.
REQ-013 out_accept  in  clog2(DISP_W+1)  number of output lanes consumed this cycle, counted from lane 0; never exceeds the number of set out_valid bits.
REQ-014 count  out  clog2(DEPTH+1)  number of occupied entries.
REQ-015 halted  out  1  sticky; set once a halt or illegal instruction has been consumed.

Function
REQ-016 Entries hold {inst, pc} in a circular buffer with head (oldest) and tail pointers that wrap modulo DEPTH.
REQ-017 Enqueue: when in_ready=1 and flush=0, the popcount of in_valid is written at tail..tail+n-1; tail advances by n.
REQ-018 When in_ready=0, in_valid is ignored: nothing is written and tail does not move.
REQ-019 in_ready depends only on registered count; same-cycle dequeues do not raise it.
REQ-020 Output lane k presents entry head+k, decoded combinationally, with out_valid[k]=1 iff k<count, halted=0, and no earlier lane decodes halt or illegal.
REQ-021 A lane whose entry decodes halt or illegal is valid; all later lanes are invalid in that cycle.
REQ-022 Dequeue: head advances by out_accept; count_next = count + enq_n - out_accept.
REQ-023 Enqueue and dequeue in the same cycle are both honoured.
REQ-024 When an accepted lane carries halt or illegal, halted is set on the next edge.
REQ-025 While halted=1: out_valid=0 and in_ready=0; only reset clears halted.
REQ-026 flush has priority over enqueue and dequeue: the next cycle has count=0 and head=tail; the halted bit is unaffected.
REQ-027 Output latency: an entry written at edge t is visible on out_valid in the cycle after t (minimum one-cycle fetch-to-decode latency).
REQ-028 out_pack of an invalid lane is don't-care, but each decoder is driven with in_valid=0 for that lane.

Reset
REQ-029 While rst_n=0, the following values hold: head=0, tail=0, count=0, halted=0, in_ready=1, out_valid=0.
REQ-030 Reset asserted mid-operation discards all entries immediately, with no completion of in-flight enqueue or dequeue.

Structure
REQ-031 INST, DECODED_PACK and XLEN come from the shared decoder header; no new shared typedefs are added.
REQ-032 The module instantiates DISP_W copies of the existing decoder sub-module, one per output lane, with flush driving each decoder's flush input.
REQ-033 The buffer is pure storage plus pointers in this module; no separate FIFO sub-module is used.

Verification
REQ-034 Reset, then enqueue 2 LUIs (32'h12345037 at pc 0, 4) with out_accept=0 -> next cycle count=2, out_valid=2'b11, lane0 pc=0.
REQ-035 Enqueue until full with DEPTH=8, FETCH_W=2 -> in_ready drops at count=7; a fourth double-enqueue while count=7 is ignored; count stays 7.
REQ-036 Steady state, 2 in and 2 out per cycle for 20 cycles -> count constant, PCs in order across pointer wrap.
REQ-037 Queue {add, halt, add}, accept 2 -> out_valid=2'b11 with lane1=halt; after acceptance halted=1, out_valid=0, in_ready=0 until reset.
REQ-038 flush asserted together with an enqueue and out_accept=1 at count=5 -> next cycle count=0, out_valid=0.
REQ-039 rst_n pulsed low asynchronously at mid-cycle with count=4 -> outputs reach their reset values before the next clock edge.
